// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle: instruction memory request/response,
// decode handshake, branch resolution and trap redirect.
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            misalign_err;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    output misalign_err,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  instr_ready,
    input  br_taken,
    input  br_target,
    input  flush,
    input  flush_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  misalign_err,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output instr_ready,
    output br_taken,
    output br_target,
    output flush,
    output flush_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch FSM,
// with branch redirect, trap flush and stale-response drain.
module fetch_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  assign fpc     = {bus.flush_pc[XLEN-1:2], 2'b00};
  assign tgt     = {bus.br_target[XLEN-1:2], 2'b00};
  assign tgt_mis = |bus.br_target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.flush) begin
          pc_d    = fpc;
          state_d = bus.imem_req_ready ? S_DRAIN : S_REQ;
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response coinciding with flush is already stale
        if (bus.flush) begin
          pc_d    = fpc;
          state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          instr_d = bus.imem_rsp_data;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.flush) begin
          pc_d    = fpc;
          state_d = S_REQ;
        end else if (bus.instr_ready) begin
          pc_d    = bus.br_taken ? tgt : pc_q + XLEN'(4);
          mis_d   = bus.br_taken & tgt_mis;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.flush) begin
          pc_d = fpc;
        end
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = ipc_q;
  assign bus.misalign_err   = mis_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage. It sits directly downstream of the branch-condition unit: it consumes br_taken and the branch target to select the next PC.
- Issues one instruction-memory request at a time over a valid/ready handshake.
- Presents the returned instruction to decode with a valid/ready handshake.
- Supports asynchronous redirect (flush) from trap logic, and discards stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address (word aligned).
- imem_rsp_valid  in  1  response valid, single-cycle pulse.
- imem_rsp_data  in  XLEN  fetched instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode/execute consumes the instruction this cycle.
- instr  out  XLEN  held instruction.
- instr_pc  out  XLEN  PC of the held instruction.
- br_taken  in  1  branch decision for the held instruction; sampled only on an instr handshake.
- br_target  in  XLEN  branch/jump target for the held instruction.
- flush  in  1  redirect request, one-cycle pulse.
- flush_pc  in  XLEN  redirect target.
- misalign_err  out  1  one-cycle pulse: taken target had bits [1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, state = IDLE.
  - imem_req_valid, instr_valid and misalign_err = 0; instr and instr_pc = 0.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
  - IDLE: next edge -> REQ. First request is visible one cycle after rst_n deasserts.
  - REQ: imem_req_valid = 1, imem_req_addr = pc. On imem_req_valid & imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, latch instr = imem_rsp_data and instr_pc = pc -> HOLD.
  - HOLD: instr_valid = 1; instr and instr_pc stay stable.
    - On instr_valid & instr_ready, pc <= br_taken ? {br_target[XLEN-1:2], 2'b00} : pc + 4, then -> REQ.
    - The next request address appears the cycle after the handshake.
  - DRAIN: wait for the outstanding response, drop it without latching, then -> REQ.
- Arithmetic: pc + 4 is modulo 2^XLEN (32'hFFFF_FFFC + 4 = 32'h0).
- Misaligned target: on a handshake with br_taken = 1 and br_target[1:0] != 0:
  - misalign_err pulses high for the following cycle;
  - the target is still used with bits [1:0] forced to 0.
- Flush (highest priority, any state except IDLE): pc <= {flush_pc[XLEN-1:2], 2'b00}, instr_valid drops next cycle.
  - REQ, not accepted this cycle: withdraw the request -> REQ with the new address. Address may change while valid only on flush.
  - REQ, accepted this same cycle: -> DRAIN.
  - WAIT: -> DRAIN. If imem_rsp_valid arrives in the same cycle as flush, the response is dropped -> REQ.
  - HOLD: instruction discarded; br_taken ignored even if instr_ready is high -> REQ.
- imem_rsp_valid outside WAIT/DRAIN is ignored. At most one request is outstanding; the response arrives no earlier than the cycle after acceptance.
- Reset asserted mid-transaction aborts everything. A late response after reset release is ignored because the FSM is in IDLE/REQ.

Test Plan:
- Reset release, imem ready always, response 1 cycle after accept, instr_ready = 1, br_taken = 0 -> addresses 0x0, 0x4, 0x8. instr_pc tracks; one instruction per 3 cycles.
- In HOLD at pc 0x100, br_taken = 1, br_target = 0x200 -> next imem_req_addr = 0x200; misalign_err stays 0.
- br_taken = 1, br_target = 0x203 -> next address 0x200; misalign_err high for exactly one cycle.
- flush (flush_pc = 0x400) in WAIT, stale response (0xDEADBEEF) two cycles later -> stale data never on instr. Next request to 0x400, and its data is presented.
- pc = 0xFFFF_FFFC, not taken -> next address 0x0000_0000.
- instr_ready held low 5 cycles in HOLD -> instr and instr_pc stable, no new request. imem_req_ready low 3 cycles in REQ -> valid and address held stable. rst_n pulsed low in WAIT -> all outputs 0 immediately; restart at RESET_PC.
